// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcodes, request
// kind encodings and the loader FSM state type.
package instr_encoder_loader_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [2:0] KIND_R    = 3'd0;
  localparam logic [2:0] KIND_ADDI = 3'd1;
  localparam logic [2:0] KIND_SLTI = 3'd2;
  localparam logic [2:0] KIND_BEQ  = 3'd3;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    FULL
  } state_e;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: turns a symbolic request into a 32-bit MIPS word.
// Kinds 4..7 are reported as illegal with a zero word.
module instr_packer
  import instr_encoder_loader_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Select the field layout by instruction class.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind)
      KIND_R:    word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
      KIND_SLTI: word = {OP_SLTI, rs, rt, imm};
      KIND_BEQ:  word = {OP_BEQ, rs, rt, imm};
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: accepts symbolic requests, packs them and writes
// them sequentially into instruction memory, one word per two cycles.
// Optional macro LOADER_CHECKSUM_EN adds checksum_o, the running XOR of all
// words actually written.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned BASE_IDX = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [5:0]        funct_i,
  input  logic [15:0]       imm_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum_o
`endif
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_IDX);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic [31:0]       word_q;
  logic              we_q;
  logic              full_q;
  logic              err_q;
  logic [31:0]       packed_word;
  logic              packed_legal;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       cks_q;
`endif

  instr_packer u_packer (
    .kind  (kind_i),
    .rs    (rs_i),
    .rt    (rt_i),
    .rd    (rd_i),
    .funct (funct_i),
    .imm   (imm_i),
    .word  (packed_word),
    .legal (packed_legal)
  );

  // Count after the write in progress completes; decides WRITE -> FULL.
  always_comb begin
    count_nxt = count_q + (ADDR_W + 1)'(1);
  end

  // Loader FSM with pointer, counter and flags; clear_i overrides every state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else if (clear_i) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      count_q <= '0;
      we_q    <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (packed_legal) begin
              word_q  <= packed_word;
              we_q    <= 1'b1;
              state_q <= WRITE;
            end else begin
              // Illegal requests are consumed without a write.
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          we_q    <= 1'b0;
          ptr_q   <= ptr_q + ADDR_W'(1);
          count_q <= count_nxt;
`ifdef LOADER_CHECKSUM_EN
          cks_q   <= cks_q ^ word_q;
`endif
          if (count_nxt == DEPTH_CNT) begin
            state_q <= FULL;
            full_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        FULL: begin
          we_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is held low while reset is asserted; clear_i suppresses a pending write.
  always_comb begin
    ready_o = (state_q == IDLE) && !rst_i;
    we_o    = we_q && !clear_i;
    waddr_o = ptr_q;
    wdata_o = word_q;
    count_o = count_q;
    full_o  = full_q;
    err_o   = err_q;
`ifdef LOADER_CHECKSUM_EN
    checksum_o = cks_q;
`endif
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader with default parameters.
module tb_instr_encoder_loader;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  kind = '0;
  logic [4:0]  rs = '0;
  logic [4:0]  rt = '0;
  logic [4:0]  rd = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [5:0]  count;
  logic        full;
  logic        err;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  cap_addr[$];
  logic [31:0] cap_data[$];
  logic [4:0]  exp_addr[$];
  logic [31:0] exp_data[$];

  instr_encoder_loader dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear),
    .valid_i (valid),
    .ready_o (ready),
    .kind_i  (kind),
    .rs_i    (rs),
    .rt_i    (rt),
    .rd_i    (rd),
    .funct_i (funct),
    .imm_i   (imm),
    .we_o    (we),
    .waddr_o (waddr),
    .wdata_o (wdata),
    .count_o (count),
    .full_o  (full),
    .err_o   (err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum_o (checksum)
`endif
  );

  always #5 clk = ~clk;

  // Record every memory write as the memory would see it.
  always @(negedge clk) begin
    if (!rst && we === 1'b1) begin
      cap_addr.push_back(waddr);
      cap_data.push_back(wdata);
    end
  end

  // Reference encoding built from the MIPS field positions.
  function automatic logic [31:0] model_word(int k, int s, int t, int d, int f, int im);
    longint op;
    longint w;
    case (k)
      0: op = 0;
      1: op = 8;
      2: op = 10;
      default: op = 4;
    endcase
    w = op * 64'd67108864 + s * 64'd2097152 + t * 64'd65536;
    if (k == 0) w = w + d * 64'd2048 + f;
    else w = w + im;
    return w[31:0];
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
    rst   = 1'b1;
    #2;
    rst = rst;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cap_addr.delete();
    cap_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  // Waits for ready, then presents one request for exactly one edge.
  task automatic send_req(input int k, input int s, input int t, input int d,
                          input int f, input int im);
    int waited = 0;
    while (ready !== 1'b1 && waited < 50) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_cmp++;
    if (waited >= 50) begin
      n_bad++;
      $display("FAIL ready_timeout: ready=%b after %0d cycles, want 1", ready, waited);
    end
    valid = 1'b1;
    kind  = 3'(k);
    rs    = 5'(s);
    rt    = 5'(t);
    rd    = 5'(d);
    funct = 6'(f);
    imm   = 16'(im);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({ready, we, full, err} !== 4'b0000 || count !== 6'd0 || waddr !== 5'd0 ||
        wdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b we=%b full=%b err=%b cnt=%0d addr=%0d data=%h, want all 0",
               ready, we, full, err, count, waddr, wdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: ready=%b want 1", ready);
    end
  endtask

  task automatic test_first_write();
    apply_reset();
    send_req(1, 0, 8, $urandom_range(31), $urandom_range(63), 5);
    n_cmp++;
    if (we !== 1'b1 || waddr !== 5'd0 || wdata !== 32'h20080005 || count !== 6'd0 ||
        ready !== 1'b0) begin
      n_bad++;
      $display("FAIL first_write: we=%b addr=%0d data=%h cnt=%0d rdy=%b, want 1 0 20080005 0 0",
               we, waddr, wdata, count, ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (we !== 1'b0 || count !== 6'd1 || ready !== 1'b1) begin
      n_bad++;
      $display("FAIL first_after: we=%b cnt=%0d rdy=%b, want 0 1 1", we, count, ready);
    end
  endtask

  task automatic test_sequence();
    apply_reset();
    send_req(0, 1, 2, 3, 32, $urandom_range(65535));
    send_req(2, 5, 4, $urandom_range(31), $urandom_range(63), 16'hFFFF);
    send_req(3, 1, 2, $urandom_range(31), $urandom_range(63), 3);
    repeat (2) @(posedge clk);
    #1;
    exp_data = '{32'h00221820, 32'h28A4FFFF, 32'h10220003};
    n_cmp++;
    if (cap_data.size() != 3) begin
      n_bad++;
      $display("FAIL seq_len: got %0d writes want 3", cap_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (cap_addr[i] !== 5'(i) || cap_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL seq_word%0d: got %0d:%h want %0d:%h", i, cap_addr[i], cap_data[i],
                   i, exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int  n = 0;
    logic err_exp = 1'b0;
    apply_reset();
    for (int j = 0; j < 24; j++) begin
      int k = $urandom_range(7);
      int s = $urandom_range(31);
      int t = $urandom_range(31);
      int d = $urandom_range(31);
      int f = $urandom_range(63);
      int im = $urandom_range(65535);
      if (k < 4) begin
        exp_addr.push_back(5'(n));
        exp_data.push_back(model_word(k, s, t, d, f, im));
        n++;
      end else begin
        err_exp = 1'b1;
      end
      send_req(k, s, t, d, f, im);
      repeat ($urandom_range(2)) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (cap_data.size() != exp_data.size() || count !== 6'(n) || err !== err_exp) begin
      n_bad++;
      $display("FAIL rand_summary: writes=%0d cnt=%0d err=%b, want %0d %0d %b",
               cap_data.size(), count, err, exp_data.size(), n, err_exp);
    end else begin
      for (int i = 0; i < n; i++) begin
        n_cmp++;
        if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL rand_word%0d: got %0d:%h want %0d:%h", i, cap_addr[i], cap_data[i],
                   exp_addr[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_fill();
    int s = $urandom_range(31);
    int t = $urandom_range(31);
    int im = $urandom_range(65535);
    logic [31:0] w;
    apply_reset();
    w = model_word(1, s, t, 0, 0, im);
    valid = 1'b1;
    kind  = 3'd1;
    rs    = 5'(s);
    rt    = 5'(t);
    imm   = 16'(im);
    repeat (80) @(posedge clk);
    #1;
    valid = 1'b0;
    n_cmp++;
    if (cap_data.size() != DEPTH) begin
      n_bad++;
      $display("FAIL fill_len: got %0d writes want %0d", cap_data.size(), DEPTH);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        n_cmp++;
        if (cap_addr[i] !== 5'(i) || cap_data[i] !== w) begin
          n_bad++;
          $display("FAIL fill_word%0d: got %0d:%h want %0d:%h", i, cap_addr[i], cap_data[i],
                   i, w);
        end
      end
    end
    n_cmp++;
    if (full !== 1'b1 || ready !== 1'b0 || count !== 6'd32 || we !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_state: full=%b rdy=%b cnt=%0d we=%b, want 1 0 32 0",
               full, ready, count, we);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++;
    if (full !== 1'b0 || ready !== 1'b1 || count !== 6'd0 || waddr !== 5'd0) begin
      n_bad++;
      $display("FAIL full_clear: full=%b rdy=%b cnt=%0d addr=%0d, want 0 1 0 0",
               full, ready, count, waddr);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    send_req(5, $urandom_range(31), $urandom_range(31), 0, 0, $urandom_range(65535));
    n_cmp++;
    if (we !== 1'b0 || err !== 1'b1 || ready !== 1'b1 || count !== 6'd0) begin
      n_bad++;
      $display("FAIL illegal: we=%b err=%b rdy=%b cnt=%0d, want 0 1 1 0", we, err, ready, count);
    end
    send_req(3, 7, 9, 0, 0, 16'h8001);
    n_cmp++;
    if (we !== 1'b1 || waddr !== 5'd0 || wdata !== model_word(3, 7, 9, 0, 0, 16'h8001) ||
        err !== 1'b1) begin
      n_bad++;
      $display("FAIL illegal_next: we=%b addr=%0d data=%h err=%b, want 1 0 %h 1",
               we, waddr, wdata, err, model_word(3, 7, 9, 0, 0, 16'h8001));
    end
  endtask

  task automatic test_clear();
    apply_reset();
    send_req(1, 2, 3, 0, 0, 7);
    clear = 1'b1;
    #1;
    n_cmp++;
    if (we !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_write_we: we=%b want 0", we);
    end
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++;
    if (count !== 6'd0 || ready !== 1'b1 || cap_data.size() != 0) begin
      n_bad++;
      $display("FAIL clear_write_after: cnt=%0d rdy=%b writes=%0d, want 0 1 0",
               count, ready, cap_data.size());
    end
    clear = 1'b1;
    valid = 1'b1;
    kind  = 3'd2;
    @(posedge clk);
    #1;
    clear = 1'b0;
    valid = 1'b0;
    n_cmp++;
    if (we !== 1'b0 || ready !== 1'b1 || count !== 6'd0) begin
      n_bad++;
      $display("FAIL clear_idle: we=%b rdy=%b cnt=%0d, want 0 1 0", we, ready, count);
    end
    send_req(0, 4, 5, 6, 42, 0);
    n_cmp++;
    if (we !== 1'b1 || waddr !== 5'd0 || wdata !== model_word(0, 4, 5, 6, 42, 0)) begin
      n_bad++;
      $display("FAIL clear_next: we=%b addr=%0d data=%h, want 1 0 %h",
               we, waddr, wdata, model_word(0, 4, 5, 6, 42, 0));
    end
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    send_req(2, 1, 1, 0, 0, 1);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (we !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_write: we=%b rdy=%b, want 0 0", we, ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (count !== 6'd0 || waddr !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_mid_after: cnt=%0d addr=%0d, want 0 0", count, waddr);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    apply_reset();
    send_req(1, 0, 8, 0, 0, 5);
    send_req(0, 1, 2, 3, 32, 0);
    @(posedge clk);
    #1;
    n_cmp++;
    if (checksum !== (32'h20080005 ^ 32'h00221820)) begin
      n_bad++;
      $display("FAIL checksum: got %h want %h", checksum, 32'h20080005 ^ 32'h00221820);
    end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    n_cmp++;
    if (checksum !== 32'd0) begin
      n_bad++;
      $display("FAIL checksum_clear: got %h want 0", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_first_write();
    test_sequence();
    test_random();
    test_fill();
    test_illegal();
    test_clear();
    test_reset_mid_write();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
